// File: rtl/nsa_pkg.sv
// -----------------------------------------------------------------------------
// nsa_pkg -- shared definitions for the nibble-serial adder.
//
// Contents:
//   NIBBLE_W : width of one digit processed per RUN cycle (4 bits)
//   state_t  : control FSM states (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : nsa_pkg

// File: rtl/nibble_serial_adder_lca.sv
// -----------------------------------------------------------------------------
// lca -- 4-bit carry lookahead unit.
//
// Produces every bit's carry-out directly from propagate/generate terms, so
// a whole nibble resolves in one cycle without a ripple chain.
//
// Ports:
//   p    in  [3:0] propagate terms (a ^ b)
//   g    in  [3:0] generate terms  (a & b)
//   cin  in        carry into bit 0
//   c    out [3:0] carry out of each bit position
//   cout out       carry out of the nibble (same as c[3])
// -----------------------------------------------------------------------------
module lca
  import nsa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] p,
  input  logic [NIBBLE_W-1:0] g,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] c,
  output logic                cout
);

  assign c[0] = g[0] | (p[0] & cin);
  assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign cout = c[3];

endmodule : lca

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder -- WIDTH-bit adder that processes one nibble per cycle.
//
// An accepted operation takes WIDTH/4 RUN cycles, least significant nibble
// first, then the result is held in DONE until the consumer takes it.
//
// Build option:
//   NSA_SUB_EN  when defined, adds port 'sub'; sub=1 computes a - b
//               (b inverted, carry-in forced to 1). Otherwise add only.
//
// Ports:
//   clk        in            clock, rising edge
//   rst        in            synchronous active-high reset
//   in_valid   in            operands presented
//   in_ready   out           block idle, can accept an operation
//   a, b       in  [WIDTH]   operands
//   cin        in            carry-in (ignored when subtracting)
//   sub        in            subtract select (NSA_SUB_EN only)
//   out_valid  out           result available
//   out_ready  in            consumer takes the result
//   sum        out [WIDTH]   result
//   cout       out           carry out of the MSB
//   ovf        out           two's-complement overflow
// -----------------------------------------------------------------------------
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NSA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam int BASE_W  = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  logic sub_sel;
`ifdef NSA_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  // Bit offset of the nibble being processed this cycle.
  logic [BASE_W-1:0]   base;
  logic [NIBBLE_W-1:0] nib_p, nib_g, nib_c;
  logic                nib_cout;

  assign base  = BASE_W'(idx_q) * BASE_W'(NIBBLE_W);
  assign nib_p = a_q[base +: NIBBLE_W] ^ b_q[base +: NIBBLE_W];
  assign nib_g = a_q[base +: NIBBLE_W] & b_q[base +: NIBBLE_W];

  lca u_lca (
    .p    (nib_p),
    .g    (nib_g),
    .cin  (carry_q),
    .c    (nib_c),
    .cout (nib_cout)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath next state. Operands are captured only in IDLE, so in_valid and
  // operand changes during RUN/DONE have no effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub_sel ? ~b : b;
          carry_d = sub_sel | cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        sum_d[base +: NIBBLE_W] = nib_p ^ {nib_c[NIBBLE_W-2:0], carry_q};
        carry_d = nib_cout;
        if (idx_q == LAST_IDX) begin
          // Index parks on the last nibble rather than wrapping.
          cout_d = nib_cout;
          ovf_d  = nib_c[NIBBLE_W-2] ^ nib_c[NIBBLE_W-1];
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder -- self-checking bench for nibble_serial_adder
// (WIDTH=32). Expected results are pushed to a queue when an operation is
// driven and popped when out_valid is seen. Subtraction vectors are included
// only when NSA_SUB_EN is defined.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder;

  localparam int W   = 32;
  localparam int LAT = W / 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         cin = 1'b0;
  logic         sub_drv = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NSA_SUB_EN
    .sub       (sub_drv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    res_t         exp;
  } vec_t;

  res_t exp_q[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic, independent of the nibble structure.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic c, input logic s);
    res_t         r;
    logic [W-1:0] yy;
    logic [W:0]   t;
    yy     = s ? ~y : y;
    t      = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s | c)};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    r.ovf  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  // Presents one operation from IDLE; returns at the negedge after acceptance.
  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                          input logic s, input bit push, input res_t exp);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    a = x; b = y; cin = c; sub_drv = s;
    in_valid = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("in_ready_run", {63'd0, in_ready}, 64'd0);
  endtask

  // Counts cycles from acceptance until out_valid, bounded.
  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(LAT));
  endtask

  task automatic compare_result(input string name);
    res_t e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_nonempty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check({name, "_sum"},  64'(sum),  64'(e.sum));
    check({name, "_cout"}, 64'(cout), 64'(e.cout));
    check({name, "_ovf"},  64'(ovf),  64'(e.ovf));
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic s, input res_t exp);
    drive_op(x, y, c, s, 1'b1, exp);
    wait_valid(name);
    compare_result(name);
    @(posedge clk);
    @(negedge clk);
    check({name, "_released"}, {62'd0, out_valid, in_ready}, 64'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0}};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1}};
    vecs[2] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, '{32'h2345_678A, 1'b0, 1'b0}};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, '{32'h0000_0001, 1'b0, 1'b0}};
    vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b1}};
    vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, '{32'hFFFF_FFFF, 1'b1, 1'b0}};
    vecs[6] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 1'b0, '{32'h0000_0000, 1'b1, 1'b0}};
    vecs[7] = '{32'h89AB_CDEF, 32'h7654_3210, 1'b0, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0}};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_state", {sum, 29'd0, cout, ovf, out_valid, in_ready}, 64'd1);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             vecs[i].exp);
    end

    // Random additions against the wide model.
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", i), ra, rb, rc, 1'b0, model(ra, rb, rc, 1'b0));
    end

`ifdef NSA_SUB_EN
    run_op("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0});
    run_op("sub_7_5", 32'd7, 32'd5, 1'b0, 1'b1, '{32'h0000_0002, 1'b1, 1'b0});
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      run_op($sformatf("rsub%0d", i), ra, rb, 1'b1, 1'b1, model(ra, rb, 1'b0, 1'b1));
    end
`endif

    // Back-pressure in DONE with fresh operands offered throughout.
    out_ready = 1'b0;
    drive_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, '{32'h8000_0000, 1'b0, 1'b1});
    wait_valid("stall");
    in_valid = 1'b1;
    a = 32'hDEAD_BEEF;
    b = 32'h1234_0000;
    cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_hold%0d", i), {sum, 28'd0, cout, ovf, out_valid, in_ready},
            {32'h8000_0000, 28'd0, 1'b0, 1'b1, 1'b1, 1'b0});
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    compare_result("stall");
    @(posedge clk);
    @(negedge clk);
    check("stall_released", {62'd0, out_valid, in_ready}, 64'b01);

    // Reset in the third RUN cycle discards the in-flight operation.
    drive_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, '{32'h0, 1'b0, 1'b0});
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_state", {sum, 29'd0, cout, ovf, out_valid, in_ready}, 64'd1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk);
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      check("abort_no_result", {63'd0, seen}, 64'd0);
    end
    run_op("after_abort", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0,
           '{32'h2345_678A, 1'b0, 1'b0});

    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_nibble_serial_adder
